// File: rtl/shared_mux_arbiter.sv
// Round-robin arbiter that funnels N_REQ valid/ready requesters through one shared
// data mux into a single registered output slot with full-throughput handoff.
module shared_mux_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ready
);

  localparam int PW = $clog2(N_REQ);

  typedef logic [PW-1:0] idx_t;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  idx_t        r_ptr;
  idx_t        r_src;
  logic [W-1:0] r_data;

  idx_t         w_winner;
  idx_t         w_ptr_nxt;
  logic [W-1:0] w_sel_data;
  logic [N_REQ-1:0] w_onehot;
  logic         w_accept;
  logic         w_any;
  logic         w_grant;

  // Index addition wrapped modulo N_REQ; one subtraction suffices since both operands are < N_REQ.
  function automatic idx_t wrap_add(input idx_t base, input int off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= (PW+1)'(N_REQ)) begin
      sum = sum - (PW+1)'(N_REQ);
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  assign w_accept = (r_state == ST_EMPTY) || out_ready;
  assign w_any    = |req_valid;
  assign w_grant  = rst_n && w_accept && w_any;

  // Scan upward from the pointer; the first valid requester wins.
  always_comb begin
    logic found;
    idx_t idx;
    found    = 1'b0;
    idx      = '0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = wrap_add(r_ptr, k);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        w_winner = idx;
      end else begin
        found    = found;
      end
    end
  end

  // Winner decode and AND-OR data mux; readiness never looks at req_data.
  always_comb begin
    w_onehot   = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_onehot[i] = (idx_t'(i) == w_winner);
      w_sel_data  = w_sel_data | (req_data[i*W +: W] & {W{w_onehot[i]}});
    end
  end

  assign req_ready = w_grant ? w_onehot : '0;
  assign w_ptr_nxt = wrap_add(w_winner, 1);

  // Output-slot occupancy: leaves FULL only when drained with nothing to replace it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (out_ready) begin
          w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word, source and pointer load only on a grant; otherwise they hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_data <= w_sel_data;
      r_src  <= w_winner;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_shared_mux_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// integer-level round-robin model with an in-order scoreboard and starvation counters.
module tb_shared_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [PW-1:0]    out_src;
  logic             out_ready;

  always #5 clk = ~clk;

  shared_mux_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_valid = 0;
  int m_data  = 0;
  int m_src   = 0;
  int m_ptr   = 0;
  int q_src[$];
  int q_data[$];
  int wait_cnt[N];
  int last_win = -1;
  logic [N-1:0] last_ready;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational ready and the scoreboard,
  // then check the registered outputs after the edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic ordy, input logic rstn);
    int win;
    int exp_rdy;
    int nv, nd, ns, np;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    rst_n     = rstn;
    #1;
    win = -1;
    if (rstn && (m_valid == 0 || ordy)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && v[c]) win = c;
      end
    end
    exp_rdy = (win >= 0) ? (1 << win) : 0;
    last_ready = req_ready;
    check_eq("req_ready", int'(req_ready), exp_rdy);
    nv = m_valid; nd = m_data; ns = m_src; np = m_ptr;
    if (!rstn) begin
      nv = 0; nd = 0; ns = 0; np = 0;
      q_src.delete();
      q_data.delete();
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
    end else begin
      if (m_valid != 0 && ordy) begin
        check_eq("sb_nonempty", int'(q_src.size() > 0), 1);
        if (q_src.size() > 0) begin
          check_eq("sb_src", int'(out_src), q_src.pop_front());
          check_eq("sb_data", int'(out_data), q_data.pop_front());
        end
      end
      if (win >= 0) begin
        nv = 1; nd = int'(d[win*W +: W]); ns = win; np = (win + 1) % N;
        q_src.push_back(win);
        q_data.push_back(nd);
        for (int i = 0; i < N; i++) begin
          if (i == win) begin
            wait_cnt[i] = 0;
          end else if (v[i]) begin
            wait_cnt[i]++;
            check_eq("starve", int'(wait_cnt[i] <= N - 1), 1);
          end else begin
            wait_cnt[i] = 0;
          end
        end
      end else if (m_valid == 0 || ordy) begin
        nv = 0;
      end
    end
    last_win = win;
    @(posedge clk);
    #1;
    m_valid = nv; m_data = nd; m_src = ns; m_ptr = np;
    check_eq("out_valid", int'(out_valid), m_valid);
    if (m_valid != 0 || !rstn) begin
      check_eq("out_data", int'(out_data), m_data);
      check_eq("out_src", int'(out_src), m_src);
    end
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic           ordy;
    logic           rstn;

    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    foreach (wait_cnt[i]) wait_cnt[i] = 0;

    step(4'b0000, '0, 1'b0, 1'b0);
    step(4'b0000, '0, 1'b0, 1'b0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_data", int'(out_data), 0);

    // All requesters streaming with an always-ready sink
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, d, 1'b1, 1'b1);
      check_eq("seq_src", int'(out_src), k % 4);
      check_eq("seq_data", int'(out_data), 'h10 + (k % 4));
      check_eq("seq_valid", int'(out_valid), 1);
    end
    step(4'b0000, d, 1'b1, 1'b1);
    check_eq("drain_valid", int'(out_valid), 0);

    // Lone requester 2 against a stalled sink
    d = {8'h00, 8'hA5, 8'h00, 8'h00};
    step(4'b0100, d, 1'b0, 1'b1);
    check_eq("single_pulse", int'(last_ready), 4'b0100);
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, d, 1'b0, 1'b1);
      check_eq("stall_ready", int'(last_ready), 0);
      check_eq("stall_data", int'(out_data), 'hA5);
      check_eq("stall_src", int'(out_src), 2);
    end
    step(4'b0000, d, 1'b1, 1'b1);
    check_eq("stall_drop", int'(out_valid), 0);

    // Fairness after a grant to the highest index
    d = {8'h33, 8'h22, 8'h11, 8'h00};
    step(4'b1000, d, 1'b1, 1'b1);
    check_eq("fair_g3", int'(last_ready), 4'b1000);
    step(4'b1001, d, 1'b1, 1'b1);
    check_eq("fair_g0", int'(last_ready), 4'b0001);
    step(4'b1001, d, 1'b1, 1'b1);
    check_eq("fair_g3b", int'(last_ready), 4'b1000);

    // Back-to-back handoff without a bubble
    d = {8'h00, 8'h77, 8'h00, 8'h00};
    step(4'b0100, d, 1'b1, 1'b1);
    check_eq("nobubble_valid", int'(out_valid), 1);
    check_eq("nobubble_data", int'(out_data), 'h77);

    // Reset while FULL and stalled
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    step(4'b0001, d, 1'b0, 1'b1);
    step(4'b1111, d, 1'b0, 1'b0);
    check_eq("rstfull_ready", int'(last_ready), 0);
    check_eq("rstfull_valid", int'(out_valid), 0);
    check_eq("rstfull_data", int'(out_data), 0);
    check_eq("rstfull_src", int'(out_src), 0);
    step(4'b1111, d, 1'b1, 1'b1);
    check_eq("rst_first_grant", int'(last_ready), 4'b0001);

    // Randomized traffic: requesters hold valid until accepted
    rv = '0;
    rd = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom_range(1, 0) == 1)) begin
          rv[i] = 1'b1;
          rd[i*W +: W] = W'($urandom);
        end
      end
      ordy = ($urandom_range(3, 0) != 0);
      rstn = ($urandom_range(499, 0) != 0);
      step(rv, rd, ordy, rstn);
      if (!rstn) begin
        rv = '0;
      end else if (last_win >= 0) begin
        rv[last_win] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
